digit_serial_adder: RTL and testbench
=====================================

# digit_serial_adder

Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair DIGIT bits per clock through a single DIGIT-bit ripple-carry slice, with the carry held in a register between digits. It generalises the 4-bit combinational ripple-carry adder to any width, trades latency for area, and adds a subtract mode, signed-overflow detection and a start/busy/done handshake. It sits between a register-file-style operand source and a result consumer in the lab datapath.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. NDIG = WIDTH/DIGIT.
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- sub  input  1  0: a+b+cin; 1: a−b (cin ignored, carry seed 1, b inverted).
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- cin  input  1  carry-in for add mode, sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  result; holds until the next completion.
- cout  output  1  carry out of bit WIDTH−1 (in sub mode 1 = no borrow).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN. Encoding: IDLE=0, RUN=1.
- IDLE with start=1 → RUN. At that edge the block latches a, latches b or ~b, seeds carry = sub ? 1 : cin, and clears the digit counter.
- Each RUN cycle:
  - feeds the low DIGIT bits of the A/B shift registers and the carry register to the slice;
  - shifts the slice sum into the top of the result shift register;
  - shifts the operands right by DIGIT;
  - registers the slice carry-out;
  - increments the counter.
- On the final digit (counter = NDIG−1):
  - load sum from the completed result register;
  - cout = slice carry-out;
  - ovf = slice carry-in-to-MSB XOR slice carry-out;
  - pulse done;
  - return to IDLE.
- start while busy=1 is ignored; there is no queueing.
- Arithmetic is modulo 2^WIDTH. Wrap-around is reported only through cout and ovf.
- Reset at any time, including mid-RUN, forces IDLE. All registers clear, no done is emitted, and the partial result is discarded.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state=IDLE, counter=0, carry=0.
- Start accepted at edge E0 → busy=1 after E0.
- Digit k is computed at edge E(k+1).
- sum, cout and ovf update, and done=1, after edge E(NDIG). busy=0 in the same cycle.
- Latency from start edge to done is NDIG cycles. The done pulse lasts exactly one cycle.
- Back-to-back: start=1 during the done cycle (busy=0) is accepted at the next edge. Throughput is one result per NDIG cycles.
- DIGIT=WIDTH gives NDIG=1: one-cycle latency, and busy is high for one cycle only.
- The counter is max(1, $clog2(NDIG)) bits wide.

## Structure
- Shared include `adder_defs.vh`:
  - state encodings ST_IDLE, ST_RUN;
  - WIDTH/DIGIT divisibility check macro.
- Sub-module `rca_nbits`:
  - combinational, parameter N;
  - ports a, b, cin, sum, cout, c_msb (carry into bit N−1; equals cin when N=1);
  - one instance of width DIGIT.
- Top level contains the FSM, counter, carry register, operand/result shift registers and output registers.

## Test plan
All cases use WIDTH=16, DIGIT=4 unless stated.
- Reset asserted, then released → busy, done, sum, cout and ovf are all 0.
- Add a=0x00FF, b=0x0001, cin=0 → sum=0x0100, cout=0, ovf=0. done is high exactly 4 cycles after the start edge, for one cycle.
- Add a=0xFFFF, b=0xFFFF, cin=1 → sum=0xFFFF, cout=1, ovf=0. Then add a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Sub a=0x8000, b=0x0001 → sum=0x7FFF, cout=1, ovf=1. Sub a=0x0003, b=0x0005 → sum=0xFFFE, cout=0, ovf=0.
- Handshake:
  - start pulses during busy → ignored, and the result is unchanged;
  - start held in the done cycle → second operation completes 4 cycles later;
  - rst_n low at cycle 2 of a run → no done, and all outputs are 0.
- Parameter sweep DIGIT=1, 4 and 16 against a reference model on 1000 random vectors per mode → results match, with latencies of 16, 4 and 1 cycles respectively.

Source files
------------

// File: rtl/digit_serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM encodings, result flags
// and elaboration-time parameter helpers.
package digit_serial_adder_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic cout;
    logic ovf;
  } flags_t;

  // WIDTH must be a whole number of digits, and a digit cannot exceed WIDTH.
  function automatic bit digit_cfg_ok(input int unsigned width, input int unsigned digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

  // Counter width: max(1, clog2(ndig)).
  function automatic int unsigned cnt_width(input int unsigned ndig);
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/rca_nbits.sv
// N-bit combinational ripple-carry slice; c_msb is the carry into bit N-1.
module rca_nbits #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  localparam int unsigned NW = N + 1;

  logic [N:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + NW'(cin);
  assign sum   = full[N-1:0];
  assign cout  = full[N];
  // Carry into the top bit recovered from its sum bit; equals cin when N=1.
  assign c_msb = full[N-1] ^ a[N-1] ^ b[N-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor: one DIGIT-bit ripple slice reused over NDIG
// cycles, carry held in a register between digits.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (!digit_cfg_ok(WIDTH, DIGIT)) begin : g_cfg_err
    $error("digit_serial_adder: WIDTH must be a non-zero multiple of DIGIT");
  end

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic             accept;
  logic             last;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nxt;
  logic [WIDTH-1:0] res_ins;
  logic [WIDTH-1:0] sum_q;
  flags_t           flags_q;
  logic             done_q;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;
  logic             slice_cmsb;

  rca_nbits #(.N(DIGIT)) u_slice (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .cin   (carry),
    .sum   (slice_sum),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  // New digit enters at the top; after NDIG shifts the result is aligned.
  assign res_ins = WIDTH'(slice_sum) << (WIDTH - DIGIT);
  assign res_nxt = (res_sh >> DIGIT) | res_ins;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand load, per-digit shift and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      carry   <= 1'b0;
      a_sh    <= '0;
      b_sh    <= '0;
      res_sh  <= '0;
      sum_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        a_sh   <= a;
        b_sh   <= sub ? ~b : b;
        carry  <= sub ? 1'b1 : cin;
        cnt    <= '0;
        res_sh <= '0;
      end else if (state == ST_RUN) begin
        a_sh   <= a_sh >> DIGIT;
        b_sh   <= b_sh >> DIGIT;
        carry  <= slice_cout;
        cnt    <= cnt + CW'(1);
        res_sh <= res_nxt;
        if (last) begin
          sum_q        <= res_nxt;
          flags_q.cout <= slice_cout;
          flags_q.ovf  <= slice_cmsb ^ slice_cout;
        end
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = flags_q.cout;
  assign ovf  = flags_q.ovf;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Scoreboard bench: three adder instances (DIGIT=1, 4, 16) checked against an
// arithmetic reference model.
module tb_digit_serial_adder;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           t0;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_v [3];
  logic         sub;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy_v [3];
  logic         done_v [3];
  logic [W-1:0] sum_v  [3];
  logic         cout_v [3];
  logic         ovf_v  [3];

  int ndig_of [3] = '{16, 4, 1};
  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub), .a(a), .b(b), .cin(cin),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[inst %0d]: got %0h expected %0h (cycle %0d)", nm, i, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference: plain integer arithmetic modulo 2^16 with signed range check.
  function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c);
    exp_t e;
    int   sv;
    int   uv;
    if (s) begin
      uv     = int'(x) - int'(y);
      sv     = int'($signed(x)) - int'($signed(y));
      e.cout = (x >= y);
    end else begin
      uv     = int'(x) + int'(y) + int'(c);
      sv     = int'($signed(x)) + int'($signed(y)) + int'(c);
      e.cout = (uv > 65535);
    end
    e.sum = W'(uv);
    e.ovf = (sv > 32767) || (sv < -32768);
    e.t0  = 0;
    return e;
  endfunction

  task automatic push(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic flush_all();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  // Present operands now, accept on the next rising edge, queue expectations.
  task automatic drive(input logic [2:0] mask, input logic s, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic c);
    exp_t e;
    sub = s; a = x; b = y; cin = c;
    for (int i = 0; i < 3; i++) start_v[i] = mask[i];
    @(posedge clk);
    #1;
    e = model(s, x, y, c);
    e.t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        push(i, e);
        check("busy_after_start", i, 32'(busy_v[i]), 32'(1));
      end
      start_v[i] = 1'b0;
    end
  endtask

  task automatic issue(input logic [2:0] mask, input logic s, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic c);
    @(negedge clk);
    drive(mask, s, x, y, c);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #2;
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) return;
    end
    fail_now("timeout_waiting_for_done");
    flush_all();
  endtask

  task automatic check_outputs_zero(input string nm);
    for (int i = 0; i < 3; i++) begin
      check({nm, "_busy"}, i, 32'(busy_v[i]), 32'(0));
      check({nm, "_done"}, i, 32'(done_v[i]), 32'(0));
      check({nm, "_sum"},  i, 32'(sum_v[i]),  32'(0));
      check({nm, "_cout"}, i, 32'(cout_v[i]), 32'(0));
      check({nm, "_ovf"},  i, 32'(ovf_v[i]),  32'(0));
    end
  endtask

  task automatic on_done(input int i);
    exp_t e;
    int   n;
    n = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      fail_now($sformatf("unexpected_done inst %0d", i));
      return;
    end
    case (i)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    check("sum",       i, 32'(sum_v[i]),  32'(e.sum));
    check("cout",      i, 32'(cout_v[i]), 32'(e.cout));
    check("ovf",       i, 32'(ovf_v[i]),  32'(e.ovf));
    check("latency",   i, 32'(cyc - e.t0), 32'(ndig_of[i]));
    check("busy_done", i, 32'(busy_v[i]), 32'(0));
  endtask

  // Monitor: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 3; i++) if (done_v[i] === 1'b1) on_done(i);
    end
  end

  initial begin
    exp_t     e1;
    logic     got;
    rst_n = 1'b0;
    sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("post_reset");

    // Directed vectors on all three instances.
    issue(3'b111, 1'b0, 16'h00FF, 16'h0001, 1'b0); wait_idle();
    issue(3'b111, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1); wait_idle();
    issue(3'b111, 1'b0, 16'h7FFF, 16'h0001, 1'b0); wait_idle();
    issue(3'b111, 1'b1, 16'h8000, 16'h0001, 1'b1); wait_idle();
    issue(3'b111, 1'b1, 16'h0003, 16'h0005, 1'b0); wait_idle();

    // Start pulse while busy must be ignored.
    issue(3'b010, 1'b0, 16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    wait_idle();
    repeat (8) @(negedge clk);
    check("ignored_start_result", 1, 32'(sum_v[1]), 32'(16'h2345));
    check("ignored_start_queue",  1, 32'(q1.size()), 32'(0));

    // Start held through the done cycle: accepted back-to-back.
    issue(3'b010, 1'b0, 16'h0F0F, 16'h0101, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (done_v[1] === 1'b1) got = 1'b1;
    end
    if (!got) fail_now("timeout_back_to_back");
    check("busy_in_done_cycle", 1, 32'(busy_v[1]), 32'(0));
    drive(3'b010, 1'b1, 16'h0100, 16'h0200, 1'b0);
    wait_idle();

    // Randomised sweep in both modes.
    for (int m = 0; m < 2; m++) begin
      for (int n = 0; n < 1000; n++) begin
        issue(3'b111, 1'(m), W'($urandom), W'($urandom), 1'($urandom));
        wait_idle();
      end
    end

    // Reset mid-run: no done, all outputs cleared.
    issue(3'b111, 1'b0, 16'hFFF0, 16'h0011, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    flush_all();
    #1;
    check_outputs_zero("mid_run_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_outputs_zero("after_abort");

    // Recovers cleanly after the aborted run.
    issue(3'b111, 1'b1, 16'h0000, 16'h0001, 1'b0); wait_idle();
    e1 = model(1'b0, 16'h8000, 16'h8000, 1'b0);
    issue(3'b111, 1'b0, 16'h8000, 16'h8000, 1'b0); wait_idle();
    check("final_cout", 1, 32'(cout_v[1]), 32'(e1.cout));
    check("queues_drained", 0, 32'(q0.size() + q1.size() + q2.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
